// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, fetch state encoding and address helper.
package instruction_fetch_pkg;

    localparam int MEMORY_ADDR_W = 32;
    localparam int INST_W        = 32;

    typedef enum logic [1:0] {
        IF_ST_IDLE  = 2'd0,
        IF_ST_FETCH = 2'd1,
        IF_ST_HOLD  = 2'd2
    } if_state_e;

    function automatic logic [MEMORY_ADDR_W-1:0] word_align(input logic [MEMORY_ADDR_W-1:0] a);
        return {a[MEMORY_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_redirect_latch.sv
// fetch_redirect_latch: remembers a redirect seen while a fetch is in flight
// and resolves it against a same-cycle redirect when the ack arrives.
module fetch_redirect_latch
    import instruction_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetching_i,
    input  logic                     imem_ack_i,
    input  logic                     redirect_valid_i,
    input  logic [MEMORY_ADDR_W-1:0] redirect_pc_i,
    output logic                     take_o,
    output logic [MEMORY_ADDR_W-1:0] target_o
);

    logic                     pend_q, pend_d;
    logic [MEMORY_ADDR_W-1:0] pend_pc_q, pend_pc_d;

    always_comb begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (fetching_i) begin
            if (imem_ack_i) begin
                pend_d = 1'b0;
            end else if (redirect_valid_i) begin
                pend_d    = 1'b1;
                pend_pc_d = word_align(redirect_pc_i);
            end
        end
    end

    // A redirect arriving in the ack cycle is newer than anything latched.
    assign take_o   = pend_q | redirect_valid_i;
    assign target_o = redirect_valid_i ? word_align(redirect_pc_i) : pend_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: holds the fetch PC, issues single-outstanding imem reads
// and hands each returned word to decode over a valid/ready handshake.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [MEMORY_ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [MEMORY_ADDR_W-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [INST_W-1:0]        imem_rdata,
    output logic                     inst_valid,
    output logic [INST_W-1:0]        inst,
    output logic [MEMORY_ADDR_W-1:0] inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect_valid,
    input  logic [MEMORY_ADDR_W-1:0] redirect_pc
);

    if_state_e                state_q, state_d;
    logic [MEMORY_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0]        inst_q, inst_d;
    logic [MEMORY_ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic                     redir_take;
    logic [MEMORY_ADDR_W-1:0] redir_target;

    fetch_redirect_latch u_redirect (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetching_i       (state_q == IF_ST_FETCH),
        .imem_ack_i       (imem_ack),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .take_o           (redir_take),
        .target_o         (redir_target)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        case (state_q)
            IF_ST_IDLE: state_d = IF_ST_FETCH;
            IF_ST_FETCH: begin
                // Address stays put until ack; a redirect only retargets afterwards.
                if (imem_ack) begin
                    if (redir_take) begin
                        fetch_pc_d = redir_target;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = fetch_pc_q;
                        state_d   = IF_ST_HOLD;
                    end
                end
            end
            IF_ST_HOLD: begin
                if (inst_ready || redirect_valid) begin
                    fetch_pc_d = redirect_valid ? word_align(redirect_pc)
                                                : inst_pc_q + MEMORY_ADDR_W'(4);
                    state_d    = IF_ST_FETCH;
                end
            end
            default: state_d = IF_ST_IDLE;
        endcase
    end

    assign imem_req   = (state_q == IF_ST_FETCH);
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (state_q == IF_ST_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IF_ST_IDLE;
            fetch_pc_q <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

endmodule
